// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin front end for the shared word RAM.
// m0 = instruction fetch, m1 = load/store. One transaction in flight;
// a watchdog aborts unacknowledged accesses and returns ERR_DATA.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,
    // master 0
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    output logic [31:0] m0_rdata,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    // master 1
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    output logic [31:0] m1_rdata,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    // slave
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    // status
    output logic        grant,
    output logic        timeout_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Counter only has to reach TIMEOUT-1; it stops there, so no wrap.
    localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LAST     = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] CNT_LAST = LAST[CW-1:0];
    localparam bit          WD_EN    = (TIMEOUT != 0);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          last_grant;

    logic          sel;
    logic          req_any;
    logic          rsp_hit;
    logic          rsp_to;
    logic [31:0]   rsp_data;

    // Arbitration pick and response source for the current cycle.
    always_comb begin
        req_any  = m0_valid | m1_valid;
        sel      = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
        rsp_hit  = mem_ready;
        rsp_to   = !mem_ready && WD_EN && (cnt == CNT_LAST);
        rsp_data = mem_ready ? mem_rdata : ERR_DATA;
    end

    // Main FSM: latch request, wait for slave or watchdog, one-cycle DONE gap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            grant       <= 1'b1;
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        mem_addr  <= sel ? m1_addr  : m0_addr;
                        mem_wdata <= sel ? m1_wdata : m0_wdata;
                        mem_wstrb <= sel ? m1_wstrb : m0_wstrb;
                        mem_valid <= 1'b1;
                        grant     <= sel;
                        cnt       <= '0;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (rsp_hit || rsp_to) begin
                        mem_valid   <= 1'b0;
                        timeout_err <= rsp_to;
                        last_grant  <= grant;
                        if (grant) begin
                            m1_rdata <= rsp_data;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= rsp_data;
                            m0_ready <= 1'b1;
                        end
                        state <= S_DONE;
                    end else if (WD_EN) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Requests ignored here so the master can drop valid.
                    m0_ready    <= 1'b0;
                    m1_ready    <= 1'b0;
                    timeout_err <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors plus corner sequences for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_wstrb;
    logic        grant, timeout_err;

    int n_cmp = 0;
    int n_fail = 0;
    int slv_delay = 0;
    logic [31:0] exp_rd [2];

    mem_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_rdata(m0_rdata), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_rdata(m1_rdata), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // RAM slave: 16 words, ready after slv_delay waiting cycles, read-before-write.
    logic [31:0] ram [16];
    logic        ram_loaded = 1'b0;
    int          wcnt = 0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'h1000_0000 + i;
            ram[4] <= 32'h1234_5678;
            ram[2] <= 32'h1122_3344;
            ram_loaded <= 1'b1;
        end else if (mem_valid && !mem_ready) begin
            if (wcnt >= slv_delay) begin
                mem_ready <= 1'b1;
                mem_rdata <= ram[mem_addr[5:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) ram[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            mem_ready <= 1'b0;
            if (!mem_valid) wcnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // One single-master transaction; called at a negedge with the DUT idle.
    task automatic txn(input string nm, input int m, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int lat;
        bit seen;
        lat = 0;
        seen = 0;
        if (m == 0) begin
            m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_valid = 1'b1;
        end else begin
            m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_valid = 1'b1;
        end
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (m0_ready || m1_ready) seen = 1;
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: no ready within 40 cycles", nm);
        end else begin
            chk({nm, "_ready_own"}, {31'd0, (m == 0) ? m0_ready : m1_ready}, 32'd1);
            chk({nm, "_ready_other"}, {31'd0, (m == 0) ? m1_ready : m0_ready}, 32'd0);
            chk({nm, "_rdata"}, (m == 0) ? m0_rdata : m1_rdata, exp_data);
            chk({nm, "_other_rdata_hold"}, (m == 0) ? m1_rdata : m0_rdata, exp_rd[1-m]);
            chk({nm, "_grant"}, {31'd0, grant}, m);
            chk({nm, "_err"}, {31'd0, timeout_err}, {31'd0, exp_err});
            if (exp_lat > 0) chk({nm, "_latency"}, lat, exp_lat);
            exp_rd[m] = exp_data;
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_ready_pulse"}, {30'd0, m1_ready, m0_ready}, 32'd0);
        chk({nm, "_err_pulse"}, {31'd0, timeout_err}, 32'd0);
    endtask

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int mv_cnt, nrdy, cyc, exp_g;
        bit prev_rdy;

        vecs[0] = '{0, 32'h10, 32'h0,         4'b0000, 32'h1234_5678};
        vecs[1] = '{1, 32'h08, 32'hAABB_CCDD, 4'b0101, 32'h1122_3344};
        vecs[2] = '{1, 32'h08, 32'h0,         4'b0000, 32'h11BB_33DD};
        vecs[3] = '{0, 32'h00, 32'hCAFE_F00D, 4'b1111, 32'h1000_0000};
        vecs[4] = '{0, 32'h00, 32'h0,         4'b0000, 32'hCAFE_F00D};
        vecs[5] = '{1, 32'h3C, 32'h0,         4'b0000, 32'h1000_000F};

        // Reset state
        do_reset();
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        chk("rst_grant", {31'd0, grant}, 32'd1);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);

        // Directed single-master vectors, 1-cycle RAM
        for (int i = 0; i < 6; i++)
            txn($sformatf("vec%0d", i), vecs[i].m, vecs[i].addr, vecs[i].wdata,
                vecs[i].wstrb, vecs[i].exp_data, 1'b0, 3);

        // Fairness: both masters hold valid for 6 completions
        do_reset();
        m0_addr = 32'h10; m0_wstrb = 4'b0; m1_addr = 32'h3C; m1_wstrb = 4'b0;
        m0_valid = 1'b1; m1_valid = 1'b1;
        nrdy = 0; cyc = 0; prev_rdy = 0; exp_g = 0;
        while (nrdy < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (m0_ready || m1_ready) begin
                chk($sformatf("fair%0d_grant", nrdy), {31'd0, grant}, exp_g);
                chk($sformatf("fair%0d_ready", nrdy), {30'd0, m1_ready, m0_ready},
                    (exp_g == 0) ? 32'd1 : 32'd2);
                chk($sformatf("fair%0d_rdata", nrdy), (exp_g == 0) ? m0_rdata : m1_rdata,
                    (exp_g == 0) ? 32'h1234_5678 : 32'h1000_000F);
                if (prev_rdy) chk($sformatf("fair%0d_width", nrdy), 32'd2, 32'd1);
                prev_rdy = 1;
                exp_g = 1 - exp_g;
                nrdy++;
            end else begin
                prev_rdy = 0;
            end
        end
        chk("fair_count", nrdy, 6);
        m0_valid = 1'b0; m1_valid = 1'b0;
        exp_rd[0] = 32'h1234_5678;
        exp_rd[1] = 32'h1000_000F;
        repeat (4) @(negedge clk);

        // Watchdog: slave never answers
        slv_delay = 1000;
        m0_addr = 32'h20; m0_wstrb = 4'b0; m0_valid = 1'b1;
        mv_cnt = 0; cyc = 0;
        while (!m0_ready && !m1_ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_valid) mv_cnt++;
        end
        chk("to_mem_valid_cycles", mv_cnt, 16);
        chk("to_m0_ready", {31'd0, m0_ready}, 32'd1);
        chk("to_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        m0_valid = 1'b0;
        @(negedge clk);
        chk("to_err_pulse", {31'd0, timeout_err}, 32'd0);
        chk("to_ready_pulse", {31'd0, m0_ready}, 32'd0);
        exp_rd[0] = 32'hDEAD_BEEF;
        slv_delay = 0;
        txn("after_to", 0, 32'h10, 32'h0, 4'b0, 32'h1234_5678, 1'b0, 3);

        // Slave ready on the same cycle the watchdog expires
        slv_delay = 14;
        txn("race", 1, 32'h10, 32'h0, 4'b0, 32'h1234_5678, 1'b0, 17);
        slv_delay = 0;

        // Reset pulse while in ACCESS
        slv_delay = 1000;
        m0_addr = 32'h10; m0_wstrb = 4'b0; m0_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_in_access", {31'd0, mem_valid}, 32'd1);
        m0_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        chk("mid_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("mid_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        chk("mid_grant", {31'd0, grant}, 32'd1);
        slv_delay = 0;
        txn("post_rst", 0, 32'h10, 32'h0, 4'b0, 32'h1234_5678, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
